ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
Decodes a WS2812 single-wire serial stream back into 24-bit pixel words. It is the receive-side counterpart of the team's ws2812 LED driver. Used for loopback self-test of the driver and for sniffing and forwarding a pixel chain in test fixtures. Each decoded word is presented with its index in the frame plus a one-cycle valid strobe; frame boundaries and protocol errors are flagged.

Parameters:
CLK_MHZ, 12, clock frequency in MHz
NUM_LEDS, 64, words per frame captured/reported; indices >= NUM_LEDS are not reported
T_THRESH, ceil(CLK_MHZ*600/1000) = 8, high-time cycles at/above which a bit decodes as 1
T_MIN_HIGH, 2, high pulses shorter than this are glitches (error)
T_MAX_HIGH, 2*CLK_MHZ = 24, high pulses longer than this are errors
T_RESET, CLK_MHZ*50 = 600, low cycles that constitute a reset/latch gap

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
din  in  1  asynchronous WS2812 serial input
rgb_data  out  24  last decoded word, MSB received first
led_num  out  8  index of word in rgb_data (0 = first after gap)
valid  out  1  one-cycle strobe: rgb_data/led_num updated
frame_done  out  1  one-cycle strobe: reset gap ended a frame containing >= 1 bit
err  out  1  one-cycle strobe: protocol error
dout  out  1  forwarded stream (see Optional Feature)

Behaviour:
- Reset values: rgb_data=0, led_num=0, valid=0, frame_done=0, err=0, dout=0, state=SYNC, all counters 0.
- Reset is synchronous and applies mid-operation; a partial word in progress is discarded silently.
- Input conditioning: 3-flop chain din->s1->s2->s3.
  - Logic uses s2 as the line level.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Counters: high_cnt and low_cnt, width $clog2(T_RESET+1), saturating, never wrap.
- shreg[23:0], bit_idx (0..23), word_cnt (8 bits, saturates at 255).
- States:
  - SYNC: wait for a clean gap. low_cnt counts while s2=0 and clears when s2=1. When low_cnt reaches T_RESET: go to IDLE, bit_idx=23, word_cnt=0. No strobes issued in SYNC.
  - IDLE: on rise go to HIGH with high_cnt=1.
  - HIGH: high_cnt increments each cycle.
    - If high_cnt > T_MAX_HIGH: err strobe, go to SYNC.
    - On fall with high_cnt < T_MIN_HIGH: err strobe, go to SYNC.
    - On any other fall: bit = (high_cnt >= T_THRESH). Shift the bit into shreg MSB-first. Go to LOW with low_cnt=1.
    - If this was bit_idx 0: next cycle rgb_data={shreg[22:0],bit}, led_num=word_cnt, and valid=1 if word_cnt < NUM_LEDS. Then word_cnt increments and bit_idx returns to 23. Otherwise bit_idx decrements.
  - LOW: low_cnt increments.
    - On rise: go to HIGH with high_cnt=1.
    - When low_cnt reaches T_RESET: frame_done strobe. Also err strobe if bit_idx != 23 (partial word). Then go to IDLE with bit_idx=23, word_cnt=0.
- Latency:
  - valid is high on the 4th rising clk edge after din falls at the end of bit 0 (2 sync + 1 edge detect + 1 output register).
  - frame_done is high T_RESET+1 cycles after the last synchronized fall.
- Strobes:
  - All strobes last exactly one cycle.
  - err and frame_done may be asserted in the same cycle.
  - valid and frame_done are never asserted in the same cycle.
- rgb_data and led_num hold their value between valid strobes.
- A width exactly T_THRESH decodes as 1.
- A high time exactly T_MAX_HIGH is legal.

Optional Feature:
- Macro: WS2812_RX_FWD_EN.
- Defined:
  - dout = s2 while word_cnt >= NUM_LEDS and state is HIGH, LOW or IDLE; dout=0 otherwise, including during error recovery (SYNC).
  - The block thus consumes the first NUM_LEDS words and regenerates the remainder downstream, delayed 2 cycles, like a chain of NUM_LEDS pixels.
- Undefined: dout is held at constant 0 and no forwarding logic is built.

Test Plan:
1. Reset; din low 600 cycles; send 0xFF0055 (1 = 11 high/4 low, 0 = 4 high/11 low) -> exactly one valid, rgb_data=0xFF0055, led_num=0, 4 cycles after the final din fall; err=0.
2. Send 3 words 0x000001, 0x800000, 0x123456, then 700 cycles low -> valid x3 with led_num 0,1,2 and matching data; one frame_done; next frame's first word reports led_num=0.
3. din toggling with valid bit waveforms immediately after reset -> no valid until 600 consecutive low cycles seen; the first word after the gap decodes as led_num=0.
4. 12 bits then a 600-cycle gap -> err and frame_done in the same cycle, no valid. Separately, a 30-cycle high pulse -> err, then no valid until a full gap.
5. Assert reset for 1 cycle mid-word (bit 10) -> all outputs 0 next cycle. After a gap, the next word decodes correctly with led_num=0.
6. WS2812_RX_FWD_EN, NUM_LEDS=2, send 3 words -> valid only for led_num 0,1. dout stays low during words 0–1, then reproduces word 2's waveform delayed 2 cycles and returns low after it.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 serial stream into 24-bit words with index, frame and error strobes.
// Define WS2812_RX_FWD_EN to forward the words beyond NUM_LEDS on dout.
module ws2812_rx #(
  parameter int CLK_MHZ    = 12,
  parameter int NUM_LEDS   = 64,
  parameter int T_THRESH   = (CLK_MHZ * 600 + 999) / 1000,
  parameter int T_MIN_HIGH = 2,
  parameter int T_MAX_HIGH = 2 * CLK_MHZ,
  parameter int T_RESET    = CLK_MHZ * 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  output logic        frame_done,
  output logic        err,
  output logic        dout
);
  localparam int CW = $clog2(T_RESET + 1);
  localparam logic [CW-1:0] THR  = CW'(T_THRESH);
  localparam logic [CW-1:0] MINH = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] MAXH = CW'(T_MAX_HIGH);
  localparam logic [CW-1:0] RST  = CW'(T_RESET);
  localparam logic [8:0]    NL   = 9'(NUM_LEDS);
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  state_t state;
  logic s1, s2, s3, pend;
  logic [CW-1:0] high_cnt, low_cnt;
  logic [23:0] shreg;
  logic [4:0] bit_idx;
  logic [7:0] word_cnt;
  logic rise, fall, bit_val;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign bit_val = high_cnt >= THR;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC;
      {s1, s2, s3, pend} <= '0;
      {high_cnt, low_cnt} <= '0;
      {shreg, bit_idx, word_cnt} <= '0;
      {rgb_data, led_num, valid, frame_done, err} <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      valid <= 1'b0;
      frame_done <= 1'b0;
      err <= 1'b0;
      pend <= 1'b0;
      // a word completed on the previous cycle is published here
      if (pend) begin
        rgb_data <= shreg;
        led_num <= word_cnt;
        valid <= {1'b0, word_cnt} < NL;
        word_cnt <= (&word_cnt) ? word_cnt : word_cnt + 8'd1;
      end
      case (state)
        SYNC: begin
          if (s2) low_cnt <= '0;
          else if (low_cnt == RST) begin
            state <= IDLE;
            bit_idx <= 5'd23;
            word_cnt <= '0;
          end else low_cnt <= low_cnt + 1'b1;
        end
        IDLE: begin
          if (rise) begin
            state <= HIGH;
            high_cnt <= CW'(1);
          end
        end
        HIGH: begin
          if (high_cnt > MAXH || (fall && high_cnt < MINH)) begin
            err <= 1'b1;
            state <= SYNC;
            low_cnt <= '0;
          end else if (fall) begin
            shreg <= {shreg[22:0], bit_val};
            state <= LOW;
            low_cnt <= CW'(1);
            pend <= bit_idx == 5'd0;
            bit_idx <= (bit_idx == 5'd0) ? 5'd23 : bit_idx - 5'd1;
          end else high_cnt <= (&high_cnt) ? high_cnt : high_cnt + 1'b1;
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            high_cnt <= CW'(1);
          end else if (low_cnt == RST) begin
            frame_done <= 1'b1;
            err <= bit_idx != 5'd23;
            state <= IDLE;
            bit_idx <= 5'd23;
            word_cnt <= '0;
          end else low_cnt <= low_cnt + 1'b1;
        end
      endcase
    end
  end
`ifdef WS2812_RX_FWD_EN
  assign dout = s2 && state != SYNC && {1'b0, word_cnt} >= NL;
`else
  assign dout = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized waveform stimulus against a word/index/latency reference model.
module tb_ws2812_rx;
  localparam int N = 4;
  localparam int TR = 600;
  localparam int TMAX = 24;
  typedef struct packed {logic [23:0] d; logic [7:0] n; logic [31:0] c;} ev_t;
  logic clk = 0, reset = 1, din = 0;
  logic [23:0] rgb_data;
  logic [7:0] led_num;
  logic valid, frame_done, err, dout;
  int cyc = 0, checks = 0, errors = 0;
  int n_fd = 0, n_err = 0, fd_cyc = 0, err_cyc = 0, overlap = 0;
  int frame_idx = 0, last_set = 0, last_fall = 0, first_set = 0;
  ev_t obs[$], exp_q[$];
  bit din_h[65536];
  bit dout_h[65536];

  ws2812_rx #(.NUM_LEDS(N)) dut (.clk(clk), .reset(reset), .din(din), .rgb_data(rgb_data),
    .led_num(led_num), .valid(valid), .frame_done(frame_done), .err(err), .dout(dout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) obs.push_back('{rgb_data, led_num, 32'(cyc)});
    if (frame_done) begin n_fd++; fd_cyc = cyc; end
    if (err) begin n_err++; err_cyc = cyc; end
    if (valid && frame_done) overlap++;
    if (cyc < 65536) begin din_h[cyc] = din; dout_h[cyc] = dout; end
  end

  task automatic drive(input logic v, input int n);
    #1 din = v;
    last_set = cyc;
    repeat (n) @(posedge clk);
  endtask

  // mode 0: random legal widths, 1: fixed 11/4 and 4/11, 2: boundary widths
  task automatic send_word(input logic [23:0] w, input int mode);
    int hi, lo;
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) hi = mode == 1 ? 11 : mode == 2 ? (i % 2 ? TMAX : 8) : int'($urandom_range(TMAX, 8));
      else hi = mode == 1 ? 4 : mode == 2 ? (i % 2 ? 7 : 2) : int'($urandom_range(7, 2));
      lo = mode == 1 ? (w[i] ? 4 : 11) : int'($urandom_range(12, 3));
      drive(1, hi);
      if (i == 23) first_set = last_set;
      drive(0, lo);
      last_fall = last_set;
    end
    if (frame_idx < N) exp_q.push_back('{w, 8'(frame_idx), 32'(last_fall + 4)});
    frame_idx++;
  endtask

  task automatic gap();
    drive(0, 700);
    frame_idx = 0;
  endtask

  task automatic start();
    #1 reset = 1;
    din = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (700) @(posedge clk);
    frame_idx = 0;
    obs.delete();
    exp_q.delete();
    n_fd = 0;
    n_err = 0;
  endtask

  task automatic test_reset();
    #1 reset = 1;
    din = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rgb_data, led_num, valid, frame_done, err, dout} !== 36'd0) begin
      errors++;
      $display("FAIL reset outputs got %h exp 0", {rgb_data, led_num, valid, frame_done, err, dout});
    end
  endtask

  task automatic test_single();
    start();
    send_word(24'hFF0055, 1);
    drive(0, 20);
    checks++;
    if (obs.size() != 1 || n_err != 0) begin
      errors++;
      $display("FAIL single count/err got %0d/%0d exp 1/0", obs.size(), n_err);
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL single word%0d got %h exp %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame();
    start();
    send_word(24'h000001, 0);
    send_word(24'h800000, 0);
    send_word(24'h123456, 0);
    gap();
    checks++;
    if (obs.size() != exp_q.size()) begin errors++; $display("FAIL frame count got %0d exp %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL frame word%0d got %h exp %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_fd != 1 || n_err != 0 || fd_cyc != last_fall + TR + 3) begin
      errors++;
      $display("FAIL frame_done n=%0d err=%0d cyc=%0d exp 1/0/%0d", n_fd, n_err, fd_cyc, last_fall + TR + 3);
    end
    obs.delete();
    exp_q.delete();
    send_word(24'($urandom), 0);
    drive(0, 20);
    checks++;
    if (obs.size() != 1 || (obs.size() == 1 && obs[0] !== exp_q[0])) begin
      errors++;
      $display("FAIL next_frame got n=%0d %h exp %h", obs.size(), obs.size() ? obs[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_sync();
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    obs.delete();
    n_fd = 0;
    n_err = 0;
    repeat (2) send_word(24'($urandom), 0);
    drive(0, 20);
    exp_q.delete();
    checks++;
    if (obs.size() != 0 || n_fd != 0 || n_err != 0) begin
      errors++;
      $display("FAIL sync strobes got v=%0d fd=%0d err=%0d exp 0/0/0", obs.size(), n_fd, n_err);
    end
    gap();
    send_word(24'($urandom), 2);
    drive(0, 20);
    checks++;
    if (obs.size() != 1 || (obs.size() == 1 && obs[0] !== exp_q[0])) begin
      errors++;
      $display("FAIL sync boundary word got n=%0d %h exp %h", obs.size(), obs.size() ? obs[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_errors();
    int t;
    start();
    for (int i = 0; i < 12; i++) begin
      drive(1, $urandom_range(20, 2));
      drive(0, $urandom_range(12, 3));
    end
    gap();
    checks++;
    if (n_err != 1 || n_fd != 1 || err_cyc != fd_cyc || obs.size() != 0) begin
      errors++;
      $display("FAIL partial got err=%0d fd=%0d cyc %0d/%0d v=%0d exp 1/1 same 0", n_err, n_fd, err_cyc, fd_cyc, obs.size());
    end
    n_err = 0;
    n_fd = 0;
    drive(1, 30);
    t = last_set;
    drive(0, 10);
    checks++;
    if (n_err != 1 || err_cyc != t + 3 + TMAX + 1) begin
      errors++;
      $display("FAIL long_high got err=%0d cyc=%0d exp 1 %0d", n_err, err_cyc, t + 3 + TMAX + 1);
    end
    send_word(24'($urandom), 0);
    drive(0, 20);
    exp_q.delete();
    gap();
    checks++;
    if (obs.size() != 0 || n_fd != 0) begin
      errors++;
      $display("FAIL recover got v=%0d fd=%0d exp 0/0", obs.size(), n_fd);
    end
    send_word(24'($urandom), 0);
    drive(0, 20);
    checks++;
    if (obs.size() != 1 || (obs.size() == 1 && obs[0] !== exp_q[0])) begin
      errors++;
      $display("FAIL after_gap got n=%0d %h exp %h", obs.size(), obs.size() ? obs[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    start();
    send_word(24'($urandom) | 24'h1, 0);
    drive(0, 20);
    checks++;
    if (obs.size() != 1 || (obs.size() == 1 && obs[0] !== exp_q[0])) begin
      errors++;
      $display("FAIL pre_reset got n=%0d %h exp %h", obs.size(), obs.size() ? obs[0] : '0, exp_q[0]);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom_range(20, 2));
      drive(0, $urandom_range(12, 3));
    end
    drive(1, 5);
    #1 reset = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rgb_data, led_num, valid, frame_done, err, dout} !== 36'd0) begin
      errors++;
      $display("FAIL mid_reset outputs got %h exp 0", {rgb_data, led_num, valid, frame_done, err, dout});
    end
    reset = 0;
    obs.delete();
    exp_q.delete();
    n_err = 0;
    gap();
    send_word(24'($urandom), 1);
    drive(0, 20);
    checks++;
    if (obs.size() != 1 || n_err != 0 || (obs.size() == 1 && obs[0] !== exp_q[0])) begin
      errors++;
      $display("FAIL post_reset got n=%0d err=%0d %h exp %h", obs.size(), n_err, obs.size() ? obs[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_forward();
    int t0, ws, bad;
    bit e;
    start();
    t0 = cyc;
    ws = 0;
    for (int w = 0; w < N + 2; w++) begin
      send_word(24'($urandom), 0);
      if (w == N) ws = first_set;
    end
    gap();
    checks++;
    if (obs.size() != N) begin errors++; $display("FAIL fwd count got %0d exp %0d", obs.size(), N); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL fwd word%0d got %h exp %h", i, obs[i], exp_q[i]); end
    end
    bad = 0;
    for (int c = t0 + 2; c < cyc - 1 && c < 65536; c++) begin
`ifdef WS2812_RX_FWD_EN
      e = (c - 2 >= ws) ? din_h[c - 2] : 1'b0;
`else
      e = 1'b0;
`endif
      if (dout_h[c] !== e) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL dout got %0d wrong cycles exp 0 (word%0d from cyc %0d)", bad, N, ws); end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL valid_with_frame_done got %0d exp 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_sync();
    test_errors();
    test_reset_mid();
    test_forward();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
